inv_mix_columns: RTL

INV_MIX_COLUMNS -- requirements
Module: inv_mix_columns

---
 rtl/inv_mix_columns_if.sv | 32 +++
 rtl/inv_mix_columns.sv | 116 +++++++++++
 2 files changed

// File: rtl/inv_mix_columns_if.sv
// rtl/inv_mix_columns_if.sv - Byte-stream handshake bundle for inv_mix_columns
`timescale 1ns/1ps

interface inv_mix_columns_if;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_ready;
    logic       out_last;

    modport master (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  out_valid,
        input  out_byte,
        output out_ready,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output out_valid,
        output out_byte,
        input  out_ready,
        output out_last
    );
endinterface

// File: rtl/inv_mix_columns.sv
// rtl/inv_mix_columns.sv - Byte-serial AES InvMixColumns; INV_MIX_COLUMNS_BYPASS_EN adds a per-column bypass port
`timescale 1ns/1ps

module inv_mix_columns (
    input  logic clock,
    input  logic reset,
`ifdef INV_MIX_COLUMNS_BYPASS_EN
    input  logic bypass,
`endif
    inv_mix_columns_if.slave bus
);

    typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] k;
    logic [1:0] j;
    logic [7:0] acc [4];
    logic [7:0] acc_upd [4];
    logic [7:0] term [4];
    logic [7:0] x1, x2, x4, x8;
    logic       in_fire;
    logic       out_fire;
    logic       byp_now;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    assign in_fire  = bus.in_valid  && (state == COLLECT);
    assign out_fire = bus.out_ready && (state == EMIT);

`ifdef INV_MIX_COLUMNS_BYPASS_EN
    // Bypass is latched with the row-0 byte; later rows follow the latched value.
    logic byp_col;
    assign byp_now = (k == 2'd0) ? bypass : byp_col;

    always_ff @(posedge clock) begin
        if (reset) begin
            byp_col <= 1'b0;
        end else if (in_fire && (k == 2'd0)) begin
            byp_col <= bypass;
        end
    end
`else
    assign byp_now = 1'b0;
`endif

    // term[n] = c[n] * a_k with c = {0E, 0B, 0D, 09}, built from xtime chains
    always_comb begin
        x1      = bus.in_byte;
        x2      = xtime(x1);
        x4      = xtime(x2);
        x8      = xtime(x4);
        term[0] = x8 ^ x4 ^ x2;
        term[1] = x8 ^ x2 ^ x1;
        term[2] = x8 ^ x4 ^ x1;
        term[3] = x8 ^ x1;
    end

    always_comb begin
        logic [1:0] ci;
        ci = 2'd0;
        for (int i = 0; i < 4; i++) begin
            ci = k - 2'(i);
            if (byp_now) begin
                acc_upd[i] = (k == 2'(i)) ? x1 : acc[i];
            end else begin
                acc_upd[i] = acc[i] ^ term[ci];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            k <= 2'd0;
            j <= 2'd0;
            for (int i = 0; i < 4; i++) acc[i] <= 8'h00;
        end else if (in_fire) begin
            k <= k + 2'd1;
            for (int i = 0; i < 4; i++) acc[i] <= acc_upd[i];
        end else if (out_fire) begin
            j <= j + 2'd1;
            if (j == 2'd3) begin
                k <= 2'd0;
                for (int i = 0; i < 4; i++) acc[i] <= 8'h00;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (in_fire && (k == 2'd3))  state_nxt = EMIT;
            EMIT:    if (out_fire && (j == 2'd3)) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == COLLECT);
        bus.out_valid = (state == EMIT);
        bus.out_last  = (state == EMIT) && (j == 2'd3);
        bus.out_byte  = (state == EMIT) ? acc[j] : 8'h00;
    end

endmodule
